// File: rtl/r2r_pkg.sv
// Shared types and constants for the R2R ladder SAR ADC controller.
package r2r_pkg;

  // Default DAC/result width in bits.
  localparam int R2R_WIDTH = 8;

  // Default number of clk cycles the ladder settles after each trial code change.
  localparam int DEFAULT_SETTLE_CYCLES = 1000;

  // SAR controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/r2r_sar_adc_sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops bring the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/r2r_sar_adc.sv
// Successive-approximation controller for the R2R ladder ADC. Drives a trial
// code into the ladder, waits for it to settle, then keeps or clears the bit
// under test based on the synchronized comparator, MSB first.
module r2r_sar_adc
  import r2r_pkg::*;
#(
  parameter int N             = R2R_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         EN,
  input  logic         comp_in,
  output logic [N-1:0] r2r_out,
  output logic [N-1:0] raw_data,
  output logic         valid,
  output logic         busy
);

  // Counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB  = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [N-1:0]  CODE_MSB = {1'b1, {(N-1){1'b0}}};

  state_t          r_state;
  logic [IW-1:0]   r_bit_idx;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_r2r_out;
  logic [N-1:0]    r_raw_data;
  logic            r_valid;
  logic            r_busy;

  logic            w_comp_s;
  logic [N-1:0]    w_decided;
  logic [N-1:0]    w_next_trial;

  sync_2ff u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (comp_in),
    .o_q   (w_comp_s)
  );

  // Resolve the bit under test and, if bits remain, raise the next trial bit.
  always_comb begin
    w_decided            = r_r2r_out;
    w_decided[r_bit_idx] = w_comp_s;
    w_next_trial         = w_decided;
    if (r_bit_idx != IDX_ZERO) begin
      w_next_trial[r_bit_idx - IDX_ONE] = 1'b1;
    end else begin
      w_next_trial = w_decided;
    end
  end

  // Conversion FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_idx  <= IDX_MSB;
      r_cnt      <= CNT_ZERO;
      r_r2r_out  <= {N{1'b0}};
      r_raw_data <= {N{1'b0}};
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (EN) begin
            r_r2r_out <= CODE_MSB;
            r_bit_idx <= IDX_MSB;
            r_cnt     <= CNT_LOAD;
            r_busy    <= 1'b1;
            r_state   <= SETTLE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SETTLE: begin
          if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= DECIDE;
          end
        end
        DECIDE: begin
          r_r2r_out <= w_next_trial;
          if (r_bit_idx != IDX_ZERO) begin
            r_bit_idx <= r_bit_idx - IDX_ONE;
            r_cnt     <= CNT_LOAD;
            r_state   <= SETTLE;
          end else begin
            r_raw_data <= w_decided;
            r_valid    <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign r2r_out  = r_r2r_out;
  assign raw_data = r_raw_data;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule
